// File: rtl/input_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_pingpong_buffer
// Description : Double-banked (ping-pong) input buffer. The writer fills one
//               bank sequentially through a valid/ready handshake while the
//               reader random-accesses the other, completed bank and then
//               releases it back to the writer. Tracks per-bank frame length
//               and flags reads beyond the frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module input_pingpong_buffer #(
  parameter int BUF_DATA_WIDTH = 16,
  parameter int BUF_DEPTH      = 16,
  parameter int BUF_ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // writer side
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic signed [BUF_DATA_WIDTH-1:0] wr_data,
  input  logic                             wr_last,
  // reader side
  output logic                             rd_avail,
  output logic        [BUF_ADDR_WIDTH:0]   rd_len,
  input  logic                             rd_en,
  input  logic        [BUF_ADDR_WIDTH-1:0] rd_addr,
  output logic signed [BUF_DATA_WIDTH-1:0] rd_data,
  output logic                             rd_valid,
  output logic                             rd_oor,
  input  logic                             rd_release
);

  // Index of the last word in a bank; reaching it closes the bank.
  localparam logic [BUF_ADDR_WIDTH-1:0] c_LAST_ADDR = BUF_ADDR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [BUF_ADDR_WIDTH:0]   c_LEN_ONE   = (BUF_ADDR_WIDTH + 1)'(1);

  // --------------------------------------------------------------------------
  // Storage and control state
  // --------------------------------------------------------------------------
  logic signed [BUF_DATA_WIDTH-1:0] r_mem [2][BUF_DEPTH];

  logic                      r_wr_bank;
  logic                      r_rd_bank;
  logic [BUF_ADDR_WIDTH-1:0] r_wr_cnt;
  logic [1:0]                r_full;
  logic [BUF_ADDR_WIDTH:0]   r_len [2];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic                    w_wr_fire;
  logic                    w_wr_close;
  logic [BUF_ADDR_WIDTH:0] w_wr_len_next;
  logic                    w_rd_fire;
  logic                    w_rd_in_range;
  logic                    w_rel_fire;

  assign wr_ready = ~r_full[r_wr_bank];
  assign rd_avail = r_full[r_rd_bank];
  assign rd_len   = r_len[r_rd_bank];

  assign w_wr_fire     = wr_valid & wr_ready;
  // A bank closes either on an explicit frame end or when its last slot fills.
  assign w_wr_close    = w_wr_fire & (wr_last | (r_wr_cnt == c_LAST_ADDR));
  assign w_wr_len_next = {1'b0, r_wr_cnt} + c_LEN_ONE;

  assign w_rd_fire     = rd_en & rd_avail;
  assign w_rd_in_range = ({1'b0, rd_addr} < rd_len);
  assign w_rel_fire    = rd_release & rd_avail;

  // --------------------------------------------------------------------------
  // Bank storage write port (contents are not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_bank][r_wr_cnt] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Writer pointer: word count within the bank and the bank being filled
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_close) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= ~r_wr_bank;
    end else if (w_wr_fire) begin
      r_wr_cnt  <= r_wr_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Bank ownership: full flags and frame lengths.
  // The writer only closes a non-full bank and the reader only releases a
  // full one, so a close and a release in the same cycle always address
  // different banks and both take effect.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= 2'b00;
      r_len[0] <= '0;
      r_len[1] <= '0;
    end else begin
      if (w_wr_close) begin
        r_full[r_wr_bank] <= 1'b1;
        r_len[r_wr_bank]  <= w_wr_len_next;
      end
      if (w_rel_fire) begin
        r_full[r_rd_bank] <= 1'b0;
        r_len[r_rd_bank]  <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reader bank pointer: advances on release
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b0;
    end else if (w_rel_fire) begin
      r_rd_bank <= ~r_rd_bank;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port. The read samples the current reader bank, so a
  // read issued together with a release still sees the outgoing bank.
  // Out-of-frame reads return zero and raise rd_oor; idle cycles keep the
  // last rd_data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end else if (w_rd_fire) begin
      rd_valid <= 1'b1;
      if (w_rd_in_range) begin
        rd_data <= r_mem[r_rd_bank][rd_addr];
        rd_oor  <= 1'b0;
      end else begin
        rd_data <= '0;
        rd_oor  <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_pingpong_buffer
// Description : Directed bench for input_pingpong_buffer. Read requests push
//               their hand-computed response into a scoreboard queue; a
//               monitor pops and compares each rd_valid beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_pingpong_buffer;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic signed [DW-1:0] wr_data = '0;
  logic                 wr_last = 1'b0;
  logic                 rd_avail;
  logic [AW:0]          rd_len;
  logic                 rd_en = 1'b0;
  logic [AW-1:0]        rd_addr = '0;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_oor;
  logic                 rd_release = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int exp_data_q[$];
  int exp_oor_q[$];

  input_pingpong_buffer #(
    .BUF_DATA_WIDTH(DW),
    .BUF_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .rd_avail  (rd_avail),
    .rd_len    (rd_len),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_oor    (rd_oor),
    .rd_release(rd_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid beat must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_rd_valid", 1, 0);
      end else begin
        chk("rd_data", int'(rd_data), exp_data_q.pop_front());
        chk("rd_oor", int'(rd_oor), exp_oor_q.pop_front());
      end
    end
  end

  // One accepted write; caller guarantees wr_ready.
  task automatic wr(input int d, input bit last);
    wr_valid = 1'b1;
    wr_data  = DW'(d);
    wr_last  = last;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // One read, optionally with release in the same cycle.
  task automatic rd(input int a, input int exp_d, input int exp_o, input bit rel);
    rd_en      = 1'b1;
    rd_addr    = AW'(a);
    rd_release = rel;
    exp_data_q.push_back(exp_d);
    exp_oor_q.push_back(exp_o);
    @(posedge clk); #1;
    rd_en      = 1'b0;
    rd_release = 1'b0;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    @(posedge clk); #1;
    rd_release = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Whole-run watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  int rd_addrs[8] = '{3, 12, 0, 15, 7, 9, 1, 14};

  initial begin
    // ---------------- reset state ----------------
    #1;
    chk("rst_rd_avail", int'(rd_avail), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_len", int'(rd_len), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Read with nothing available is ignored (monitor flags any rd_valid).
    rd_en = 1'b1; rd_addr = 4'd2;
    idle(1);
    rd_en = 1'b0;
    chk("ign_rd_valid", int'(rd_valid), 0);

    // ---------------- T1: full bank0, 1..16 ----------------
    for (int i = 0; i < DEPTH; i++) wr(i + 1, 1'b0);
    chk("t1_rd_avail", int'(rd_avail), 1);
    chk("t1_rd_len", int'(rd_len), 16);
    chk("t1_wr_ready", int'(wr_ready), 1);
    rd(5, 6, 0, 1'b0);
    rd(15, 16, 0, 1'b0);

    // ---------------- T2: both banks full, stalled write ----------------
    for (int i = 0; i < DEPTH; i++) wr(101 + i, 1'b0);
    chk("t2_wr_ready_full", int'(wr_ready), 0);
    wr_valid = 1'b1; wr_data = 16'sd999; wr_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t2_stall_wr_ready", int'(wr_ready), 0);
    end
    rd(0, 1, 0, 1'b1);             // read + release bank0 while write is held
    chk("t2_wr_ready_free", int'(wr_ready), 1);
    idle(1);                       // held 999 accepted into bank0 addr 0
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("t2_wr_ready_again_full", int'(wr_ready), 0);
    chk("t2_rd_len_bank1", int'(rd_len), 16);
    rd(15, 116, 0, 1'b0);
    rd(7, 108, 0, 1'b0);
    release_bank();
    chk("t2_rd_len_single", int'(rd_len), 1);
    rd(0, 999, 0, 1'b0);
    rd(1, 0, 1, 1'b0);
    release_bank();
    chk("t2_rd_avail_empty", int'(rd_avail), 0);

    // ---------------- T3: short signed frame into bank1 ----------------
    wr(-7, 1'b0);
    wr(0, 1'b0);
    wr(9, 1'b1);
    chk("t3_rd_avail", int'(rd_avail), 1);
    chk("t3_rd_len", int'(rd_len), 3);
    rd(0, -7, 0, 1'b0);
    rd(3, 0, 1, 1'b0);
    rd(2, 9, 0, 1'b0);
    release_bank();
    chk("t3_rd_avail_after_rel", int'(rd_avail), 0);

    // ---------------- T5: stream bank1 while reading bank0 ----------------
    for (int i = 0; i < DEPTH; i++) wr(i * 3 - 20, 1'b0);
    fork
      begin
        for (int i = 0; i < DEPTH; i++) wr(200 + i, 1'b0);
      end
      begin
        for (int k = 0; k < 8; k++) rd(rd_addrs[k], rd_addrs[k] * 3 - 20, 0, 1'b0);
      end
    join
    chk("t5_wr_ready_full", int'(wr_ready), 0);

    // ---------------- T4: read + release same cycle on bank0 ----------------
    rd(2, 2 * 3 - 20, 0, 1'b1);
    chk("t4_rd_len_bank1", int'(rd_len), 16);
    chk("t4_wr_ready_bank0", int'(wr_ready), 1);
    for (int i = 0; i < 5; i++) wr(50 + i, i == 4);
    rd(15, 215, 0, 1'b0);
    release_bank();
    chk("t4_rd_len_bank0", int'(rd_len), 5);
    rd(4, 54, 0, 1'b0);
    rd(5, 0, 1, 1'b0);
    release_bank();

    // ---------------- T6: reset mid-fill and during rd_valid ----------------
    for (int i = 0; i < DEPTH; i++) wr(300 + i, 1'b0);   // bank1 full
    for (int i = 0; i < 7; i++) wr(400 + i, 1'b0);       // bank0 wr_cnt=7
    rd_en = 1'b1; rd_addr = 4'd3;
    idle(1);
    rd_en = 1'b0;
    chk("t6_rd_valid_pre", int'(rd_valid), 1);
    chk("t6_rd_data_pre", int'(rd_data), 303);
    rst_n = 1'b0;
    #1;
    chk("t6_rd_valid", int'(rd_valid), 0);
    chk("t6_rd_data", int'(rd_data), 0);
    chk("t6_rd_avail", int'(rd_avail), 0);
    chk("t6_wr_ready", int'(wr_ready), 1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    wr(77, 1'b1);
    chk("t6_rd_len", int'(rd_len), 1);
    rd(0, 77, 0, 1'b0);

    idle(3);
    chk("scoreboard_drained", exp_data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
